tx_width_gearbox: RTL and testbench
===================================

// Module: tx_width_gearbox
// PURPOSE
//  Sits between the PIPE TX parallel interface and the symbol-rate serializer, on the divide-by-10 symbol clock.
//  Takes 8/16/32-bit words (1/2/4 symbol lanes) over a valid/ready handshake and emits one 8-bit symbol
//  plus K flag per clock, lane 0 first. Two-entry word buffering gives gap-free back-to-back streaming.
// PARAMETERS
//  MAX_W  32  widest input word, in bits
//  SYM_W  8   symbol width, in bits
// PORTS
//  Bit_Rate_CLK_10  in   1       symbol clock (bit rate / 10)
//  Rst              in   1       reset, asynchronous, active-low
//  DataBusWidth     in   6       6'd8 / 6'd16 / 6'd32 => 1 / 2 / 4 lanes; any other value => 1 lane
//  Data_In          in   MAX_W   input word; lane i = Data_In[8i+7:8i]
//  DataK_In         in   4       per-lane K flag; bit i belongs to lane i
//  In_Valid         in   1       Data_In / DataK_In / DataBusWidth valid
//  In_Ready         out  1       gearbox can take a word this cycle
//  Sym_Out          out  SYM_W   output symbol (registered)
//  Sym_K            out  1       K flag of Sym_Out (registered)
//  Sym_Valid        out  1       Sym_Out holds a real symbol (registered)
//  Underflow        out  1       1-cycle pulse: stream ran dry after emitting
// BEHAVIOUR
//  Storage
//   - HR: holding word with K bits, lane count and a full flag.
//   - SR: shift word with K bits and sr_rem, the lanes still to emit (0..3).
//  Handshake
//   - Transfer occurs when In_Valid && In_Ready at a rising edge.
//   - In_Ready = Rst && (!hr_full || sr_rem==0). It is driven from flops only and has no In_Valid dependency.
//   - The word, its K bits and its lane count (decoded from DataBusWidth) are captured into HR at transfer.
//   - Later DataBusWidth changes never affect a captured word.
//   - Unused upper lanes of narrow words are ignored.
//  Per-edge datapath
//   - If sr_rem!=0: emit SR lane 0, shift SR right 8 bits (K right 1), sr_rem--.
//   - Else if hr_full: emit HR lane 0, load SR with HR>>8 (K>>1), set sr_rem = lanes-1, clear hr_full.
//     A transfer on the same edge sets hr_full again with the new word.
//   - Else: idle. Sym_Out=8'h00, Sym_K=0, Sym_Valid=0.
//   - Emitted symbols drive Sym_Out/Sym_K with Sym_Valid=1.
//  Latency
//   - Transfer at edge t with gearbox idle: first symbol valid after edge t+1.
//   - Remaining lanes follow on consecutive edges.
//  States (from sr_rem / hr_full)
//   - EMPTY: sr_rem==0, !hr_full.
//   - RUN: otherwise.
//   - EMPTY -> RUN on transfer. RUN -> EMPTY when the last lane emits with HR empty.
//  Underflow
//   - Registered.
//   - Pulses for exactly 1 cycle on the first idle cycle following a valid symbol.
//  Throughput
//   - 1 symbol/cycle sustained for every width when In_Valid is held high.
//   - In_Ready drops only while HR is full and SR is still busy.
//  Reset
//   - Asynchronous, active-low.
//   - Clears HR, SR, sr_rem, hr_full and all outputs: Sym_Out=0, Sym_K=0, Sym_Valid=0, Underflow=0, In_Ready=0.
//   - Reset mid-word discards all pending lanes. No residual symbol appears after release.
//   - In_Ready=1 on the first cycle after release.
// TESTING
//  1. Width 16, single word 32'hAABB_1122, K=0 -> Sym_Out 8'h22 then 8'h11 on consecutive cycles; next cycle Sym_Valid=0, Underflow=1 for one cycle.
//  2. Width 32, back-to-back 32'h0403_0201 and 32'h0807_0605, In_Valid held -> symbols 01..08 with no gap; In_Ready low 3 cycles during the second word.
//  3. Width 8, In_Valid continuous with bytes 0xA0..0xA7 -> one symbol per cycle; In_Ready constantly 1; Underflow never asserted.
//  4. Width 32, Data_In=32'h0000_00BC, DataK_In=4'b0001 -> Sym_K=1 for 8'hBC only; 0 for the other three lanes.
//  5. DataBusWidth=6'd12, Data_In=32'h1234_5678 -> single symbol 8'h78, then idle.
//     Width changed to 6'd32 mid-word -> the captured word's lane count is unaffected.
//  6. Rst low after the 2nd lane of a 32-bit word -> all outputs 0 immediately; after release no symbols until a new transfer.

Source files
------------

// File: rtl/tx_width_gearbox.sv
// Width gearbox between the PIPE TX parallel word interface and the symbol serializer:
// accepts 1/2/4-lane words over valid/ready and emits one symbol plus K flag per clock, lane 0 first.
module tx_width_gearbox #(
  parameter int MAX_W = 32,
  parameter int SYM_W = 8
) (
  input  logic                     Bit_Rate_CLK_10,
  input  logic                     Rst,
  input  logic [5:0]               DataBusWidth,
  input  logic [MAX_W-1:0]         Data_In,
  input  logic [MAX_W/SYM_W-1:0]   DataK_In,
  input  logic                     In_Valid,
  output logic                     In_Ready,
  output logic [SYM_W-1:0]         Sym_Out,
  output logic                     Sym_K,
  output logic                     Sym_Valid,
  output logic                     Underflow
);

  localparam int LANES = MAX_W / SYM_W;
  localparam int LW    = $clog2(LANES + 1);
  localparam int RW    = (LANES > 1) ? $clog2(LANES) : 1;

  logic [MAX_W-1:0] hr_data_q, hr_data_d;
  logic [LANES-1:0] hr_k_q, hr_k_d;
  logic [LW-1:0]    hr_lanes_q, hr_lanes_d;
  logic             hr_full_q, hr_full_d;
  logic [MAX_W-1:0] sr_data_q, sr_data_d;
  logic [LANES-1:0] sr_k_q, sr_k_d;
  logic [RW-1:0]    sr_rem_q, sr_rem_d;
  logic [SYM_W-1:0] sym_q, sym_d;
  logic             symk_q, symk_d;
  logic             symv_q, symv_d;
  logic             uflow_q, uflow_d;
  logic             xfer;

  // Unrecognised widths fall back to a single lane.
  function automatic logic [LW-1:0] decode_lanes(input logic [5:0] w);
    case (w)
      6'd8:    decode_lanes = LW'(1);
      6'd16:   decode_lanes = LW'(2);
      6'd32:   decode_lanes = LW'(4);
      default: decode_lanes = LW'(1);
    endcase
  endfunction

  // Ready depends only on stored state, so the upstream valid never loops back into it.
  assign In_Ready = Rst && (!hr_full_q || (sr_rem_q == '0));
  assign xfer     = In_Valid && In_Ready;

  always_comb begin
    hr_data_d  = hr_data_q;
    hr_k_d     = hr_k_q;
    hr_lanes_d = hr_lanes_q;
    hr_full_d  = hr_full_q;
    sr_data_d  = sr_data_q;
    sr_k_d     = sr_k_q;
    sr_rem_d   = sr_rem_q;
    sym_d      = '0;
    symk_d     = 1'b0;
    symv_d     = 1'b0;

    if (sr_rem_q != '0) begin
      sym_d     = sr_data_q[SYM_W-1:0];
      symk_d    = sr_k_q[0];
      symv_d    = 1'b1;
      sr_data_d = sr_data_q >> SYM_W;
      sr_k_d    = sr_k_q >> 1;
      sr_rem_d  = sr_rem_q - RW'(1);
    end else if (hr_full_q) begin
      sym_d     = hr_data_q[SYM_W-1:0];
      symk_d    = hr_k_q[0];
      symv_d    = 1'b1;
      sr_data_d = hr_data_q >> SYM_W;
      sr_k_d    = hr_k_q >> 1;
      sr_rem_d  = RW'(hr_lanes_q - LW'(1));
      hr_full_d = 1'b0;
    end

    // A word accepted on the same edge that HR drains refills it immediately.
    if (xfer) begin
      hr_data_d  = Data_In;
      hr_k_d     = DataK_In;
      hr_lanes_d = decode_lanes(DataBusWidth);
      hr_full_d  = 1'b1;
    end

    uflow_d = symv_q && !symv_d;
  end

  always_ff @(posedge Bit_Rate_CLK_10 or negedge Rst) begin
    if (!Rst) begin
      hr_data_q  <= '0;
      hr_k_q     <= '0;
      hr_lanes_q <= '0;
      hr_full_q  <= 1'b0;
      sr_data_q  <= '0;
      sr_k_q     <= '0;
      sr_rem_q   <= '0;
      sym_q      <= '0;
      symk_q     <= 1'b0;
      symv_q     <= 1'b0;
      uflow_q    <= 1'b0;
    end else begin
      hr_data_q  <= hr_data_d;
      hr_k_q     <= hr_k_d;
      hr_lanes_q <= hr_lanes_d;
      hr_full_q  <= hr_full_d;
      sr_data_q  <= sr_data_d;
      sr_k_q     <= sr_k_d;
      sr_rem_q   <= sr_rem_d;
      sym_q      <= sym_d;
      symk_q     <= symk_d;
      symv_q     <= symv_d;
      uflow_q    <= uflow_d;
    end
  end

  assign Sym_Out   = sym_q;
  assign Sym_K     = symk_q;
  assign Sym_Valid = symv_q;
  assign Underflow = uflow_q;

endmodule

// File: tb/tb_tx_width_gearbox.sv
// Directed bench for tx_width_gearbox: inputs change on the falling edge, outputs are checked there too.
module tb_tx_width_gearbox;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  width;
  logic [31:0] data;
  logic [3:0]  datak;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  sym_out;
  logic        sym_k;
  logic        sym_valid;
  logic        underflow;

  int n_total = 0;
  int n_pass  = 0;

  tx_width_gearbox #(.MAX_W(32), .SYM_W(8)) dut (
    .Bit_Rate_CLK_10 (clk),
    .Rst             (rst_n),
    .DataBusWidth    (width),
    .Data_In         (data),
    .DataK_In        (datak),
    .In_Valid        (in_valid),
    .In_Ready        (in_ready),
    .Sym_Out         (sym_out),
    .Sym_K           (sym_k),
    .Sym_Valid       (sym_valid),
    .Underflow       (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_sym(input string tag, input logic [7:0] s, input logic k);
    check({tag, ".valid"}, {31'd0, sym_valid}, 32'd1);
    check({tag, ".sym"},   {24'd0, sym_out},   {24'd0, s});
    check({tag, ".k"},     {31'd0, sym_k},     {31'd0, k});
  endtask

  task automatic check_idle(input string tag, input logic uf);
    check({tag, ".valid"}, {31'd0, sym_valid}, 32'd0);
    check({tag, ".sym"},   {24'd0, sym_out},   32'd0);
    check({tag, ".uf"},    {31'd0, underflow}, {31'd0, uf});
  endtask

  initial begin
    rst_n    = 1'b0;
    width    = 6'd8;
    data     = '0;
    datak    = '0;
    in_valid = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst.ready", {31'd0, in_ready}, 32'd0);
    check_idle("rst", 1'b0);
    check("rst.k", {31'd0, sym_k}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rel.ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);

    // test 1: width 16 single word
    width = 6'd16; data = 32'hAABB_1122; datak = 4'h0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_idle("t1.lat", 1'b0);
    tick(); check_sym("t1.s0", 8'h22, 1'b0);
    tick(); check_sym("t1.s1", 8'h11, 1'b0);
    tick(); check_idle("t1.end", 1'b1);
    tick(); check_idle("t1.post", 1'b0);

    // test 2: width 32 back-to-back
    width = 6'd32; data = 32'h0403_0201; in_valid = 1'b1;
    tick();
    check("t2.rdy0", {31'd0, in_ready}, 32'd1);
    data = 32'h0807_0605;
    tick();
    in_valid = 1'b0;
    check_sym("t2.s1", 8'h01, 1'b0);
    check("t2.rdy1", {31'd0, in_ready}, 32'd0);
    tick(); check_sym("t2.s2", 8'h02, 1'b0); check("t2.rdy2", {31'd0, in_ready}, 32'd0);
    tick(); check_sym("t2.s3", 8'h03, 1'b0); check("t2.rdy3", {31'd0, in_ready}, 32'd0);
    tick(); check_sym("t2.s4", 8'h04, 1'b0); check("t2.rdy4", {31'd0, in_ready}, 32'd1);
    for (int i = 5; i <= 8; i++) begin
      tick();
      check_sym($sformatf("t2.s%0d", i), 8'(i), 1'b0);
      check($sformatf("t2.uf%0d", i), {31'd0, underflow}, 32'd0);
    end
    tick(); check_idle("t2.end", 1'b1);
    tick();

    // test 3: width 8 continuous stream
    width = 6'd8;
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        data = 32'hA0 + 32'(i); in_valid = 1'b1;
        check($sformatf("t3.rdy%0d", i), {31'd0, in_ready}, 32'd1);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (i >= 1) begin
        check_sym($sformatf("t3.s%0d", i - 1), 8'hA0 + 8'(i - 1), 1'b0);
        check($sformatf("t3.uf%0d", i - 1), {31'd0, underflow}, 32'd0);
      end
    end
    tick(); check_idle("t3.end", 1'b1);
    tick();

    // test 4: K flag on lane 0 only
    width = 6'd32; data = 32'h0000_00BC; datak = 4'b0001; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; datak = 4'h0;
    tick(); check_sym("t4.l0", 8'hBC, 1'b1);
    tick(); check_sym("t4.l1", 8'h00, 1'b0);
    tick(); check_sym("t4.l2", 8'h00, 1'b0);
    tick(); check_sym("t4.l3", 8'h00, 1'b0);
    tick(); check_idle("t4.end", 1'b1);
    tick();

    // test 5: illegal width, then width change after capture
    width = 6'd12; data = 32'h1234_5678; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; width = 6'd32;
    tick(); check_sym("t5.s0", 8'h78, 1'b0);
    tick(); check_idle("t5.end", 1'b1);
    tick(); check_idle("t5.post", 1'b0);
    width = 6'd16; data = 32'hDEAD_BEEF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; width = 6'd32;
    tick(); check_sym("t5.w0", 8'hEF, 1'b0);
    tick(); check_sym("t5.w1", 8'hBE, 1'b0);
    tick(); check_idle("t5.wend", 1'b1);
    tick();

    // test 6: reset mid-word
    width = 6'd32; data = 32'h4433_2211; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); check_sym("t6.l0", 8'h11, 1'b0);
    tick(); check_sym("t6.l1", 8'h22, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_idle("t6.rst", 1'b0);
    check("t6.rst.k", {31'd0, sym_k}, 32'd0);
    check("t6.rst.rdy", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("t6.rel.rdy", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_idle($sformatf("t6.quiet%0d", i), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
